// File: rtl/axi_master_read_channel.sv
// AXI4 single-outstanding read master: one burst on AR, R beats collected into a 2-entry output FIFO.
// Optional RLAST consistency checking is enabled with `define AXI_MASTER_RLAST_CHECK_EN.
module axi_master_read_channel #(
    parameter int unsigned ADDR_WIDTH         = 32,
    parameter int unsigned READ_CHANNEL_WIDTH = 32,
    parameter int unsigned READ_BURST_LEN     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [READ_BURST_LEN-1:0]     req_len,
    output logic                          ARVALID,
    input  logic                          ARREADY,
    output logic [ADDR_WIDTH-1:0]         ARADDR,
    output logic [READ_BURST_LEN-1:0]     ARLEN,
    output logic [2:0]                    ARSIZE,
    output logic [1:0]                    ARBURST,
    input  logic                          RVALID,
    output logic                          RREADY,
    input  logic [READ_CHANNEL_WIDTH-1:0] RDATA,
    input  logic                          RLAST,
    input  logic [1:0]                    RRESP,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [READ_CHANNEL_WIDTH-1:0] out_data,
    output logic                          out_last,
    output logic                          done,
    output logic                          err
);

    localparam int unsigned DW      = READ_CHANNEL_WIDTH;
    localparam int unsigned LW      = READ_BURST_LEN;
    localparam logic [2:0]  SIZE_C  = 3'($clog2(READ_CHANNEL_WIDTH / 8));

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LW-1:0]           len_q, len_d;
    logic [LW-1:0]           cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    done_q, done_d;
    logic                    req_ready_q;
    logic                    arvalid_q;

    logic [DW-1:0]           head_data_q, head_data_d;
    logic                    head_last_q, head_last_d;
    logic                    head_vld_q, head_vld_d;
    logic [DW-1:0]           tail_data_q, tail_data_d;
    logic                    tail_last_q, tail_last_d;
    logic                    tail_vld_q, tail_vld_d;

    logic                    r_beat;
    logic                    beat_last;
    logic                    pop;
    logic                    unused_bits;

    // Tail is only ever occupied behind a valid head, so it alone marks a full FIFO.
    assign RREADY    = (state_q == DATA) && !tail_vld_q;
    assign r_beat    = RVALID && RREADY;
    assign beat_last = (cnt_q == len_q);
    assign pop       = head_vld_q && out_ready;

`ifdef AXI_MASTER_RLAST_CHECK_EN
    assign unused_bits = RRESP[0];
`else
    assign unused_bits = ^{RLAST, RRESP[0]};
`endif

    // Burst sequencing, beat counting and error collection.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d  = req_addr;
                    len_d   = req_len;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (arvalid_q && ARREADY) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (r_beat) begin
                    cnt_d = cnt_q + LW'(1);
                    if (RRESP[1]) begin
                        err_d = 1'b1;
                    end
`ifdef AXI_MASTER_RLAST_CHECK_EN
                    if (RLAST != beat_last) begin
                        err_d = 1'b1;
                    end
`endif
                    if (beat_last) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Two-entry FIFO with a registered head; simultaneous push/pop at one entry refills the head.
    always_comb begin
        head_data_d = head_data_q;
        head_last_d = head_last_q;
        head_vld_d  = head_vld_q;
        tail_data_d = tail_data_q;
        tail_last_d = tail_last_q;
        tail_vld_d  = tail_vld_q;
        if (pop) begin
            if (tail_vld_q) begin
                head_data_d = tail_data_q;
                head_last_d = tail_last_q;
                tail_vld_d  = 1'b0;
            end else if (r_beat) begin
                head_data_d = RDATA;
                head_last_d = beat_last;
            end else begin
                head_vld_d  = 1'b0;
            end
        end else if (r_beat) begin
            if (!head_vld_q) begin
                head_data_d = RDATA;
                head_last_d = beat_last;
                head_vld_d  = 1'b1;
            end else begin
                tail_data_d = RDATA;
                tail_last_d = beat_last;
                tail_vld_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            req_ready_q <= 1'b1;
            arvalid_q   <= 1'b0;
            head_data_q <= '0;
            head_last_q <= 1'b0;
            head_vld_q  <= 1'b0;
            tail_data_q <= '0;
            tail_last_q <= 1'b0;
            tail_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            done_q      <= done_d;
            req_ready_q <= (state_d == IDLE);
            arvalid_q   <= (state_d == ADDR);
            head_data_q <= head_data_d;
            head_last_q <= head_last_d;
            head_vld_q  <= head_vld_d;
            tail_data_q <= tail_data_d;
            tail_last_q <= tail_last_d;
            tail_vld_q  <= tail_vld_d;
        end
    end

    assign req_ready = req_ready_q;
    assign ARVALID   = arvalid_q;
    assign ARADDR    = addr_q;
    assign ARLEN     = len_q;
    assign ARSIZE    = SIZE_C;
    assign ARBURST   = 2'b01;
    assign out_valid = head_vld_q;
    assign out_data  = head_data_q;
    assign out_last  = head_last_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_axi_master_read_channel.sv
// Self-checking bench: AXI slave model, scoreboard of expected output beats, done/latency monitor.
module tb_axi_master_read_channel;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        RVALID;
    logic        RREADY;
    logic [31:0] RDATA;
    logic        RLAST;
    logic [1:0]  RRESP;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        done;
    logic        err;

`ifdef AXI_MASTER_RLAST_CHECK_EN
    localparam logic RLAST_ERR_EXP = 1'b1;
`else
    localparam logic RLAST_ERR_EXP = 1'b0;
`endif

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [32:0] exp_q[$];
    logic [31:0] exp_addr;
    logic [7:0]  exp_len;
    int          pop_cnt = 0;

    // Slave model state
    int          ar_delay      = 0;
    bit          rand_mode     = 0;
    int          err_beat      = -1;
    int          bad_last_beat = -1;
    bit          s_active      = 0;
    int          s_beat        = 0;
    int          s_len         = 0;
    logic [31:0] s_addr        = '0;
    int          ar_high_cnt   = 0;
    int          r_hs_total    = 0;
    logic [15:0] lfsr          = 16'hACE1;

    axi_master_read_channel dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RLAST(RLAST), .RRESP(RRESP),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a, input int b);
        return {a[15:0], 8'(b), 8'hC3};
    endfunction

    // AXI slave: AR acceptance after ar_delay stall cycles, R beats with a known pattern.
    initial begin : slave
        logic        ar_hs;
        logic        r_hs;
        logic [31:0] araddr_s;
        logic [7:0]  arlen_s;
        ARREADY = 1'b0;
        RVALID  = 1'b0;
        RDATA   = '0;
        RLAST   = 1'b0;
        RRESP   = 2'b00;
        forever begin
            @(negedge clk);
            ar_hs = 1'b0;
            r_hs  = 1'b0;
            if (!rst) begin
                ar_hs    = ARVALID && ARREADY;
                r_hs     = RVALID && RREADY;
                araddr_s = ARADDR;
                arlen_s  = ARLEN;
                if (ARVALID) begin
                    chk("araddr_stable", ARADDR, exp_addr);
                    chk("arlen_stable", ARLEN, exp_len);
                    ar_high_cnt++;
                end
            end
            @(posedge clk);
            #1;
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            if (rst) begin
                s_active    = 0;
                ar_high_cnt = 0;
                ARREADY     = 1'b0;
                RVALID      = 1'b0;
            end else begin
                if (ar_hs) begin
                    chk("ar_wait_cycles", ar_high_cnt, ar_delay + 1);
                    ar_high_cnt = 0;
                    s_active    = 1;
                    s_beat      = 0;
                    s_len       = int'(arlen_s);
                    s_addr      = araddr_s;
                end
                if (r_hs) begin
                    r_hs_total++;
                    s_beat++;
                    if (s_beat > s_len) s_active = 0;
                end
                ARREADY = (ar_delay == 0) || (ar_high_cnt >= ar_delay);
                if (!(RVALID && !r_hs)) begin
                    if (s_active && (!rand_mode || lfsr[0])) begin
                        RVALID = 1'b1;
                        RDATA  = pat(s_addr, s_beat);
                        RLAST  = (s_beat == s_len) ^ (s_beat == bad_last_beat);
                        RRESP  = (s_beat == err_beat) ? 2'b10 : 2'b00;
                    end else begin
                        RVALID = 1'b0;
                    end
                end
            end
        end
    end

    // Output scoreboard, R-to-out latency and done-pulse monitor.
    initial begin : monitor
        logic [32:0] e;
        logic        prev_r_hs;
        logic        prev_final;
        prev_r_hs  = 1'b0;
        prev_final = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_r_hs  = 1'b0;
                prev_final = 1'b0;
            end else begin
                chk("done_pulse", done, prev_final);
                if (prev_final) chk("req_ready_at_done", req_ready, 1);
                if (prev_r_hs) chk("out_latency", out_valid, 1);
                if (out_valid && out_ready) begin
                    pop_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", out_data, e[32:1]);
                        chk("out_last", out_last, e[0]);
                    end
                end
                prev_r_hs  = RVALID && RREADY;
                prev_final = prev_r_hs && s_active && (s_beat == s_len);
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_arvalid"}, ARVALID, 0);
        chk({tag, "_araddr"}, ARADDR, 0);
        chk({tag, "_arlen"}, ARLEN, 0);
        chk({tag, "_rready"}, RREADY, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_arsize"}, ARSIZE, 3'b010);
        chk({tag, "_arburst"}, ARBURST, 2'b01);
    endtask

    task automatic issue(input logic [31:0] a, input int l);
        int n = 0;
        for (int i = 0; i <= l; i++) exp_q.push_back({pat(a, i), (i == l)});
        exp_addr = a;
        exp_len  = 8'(l);
        while (!req_ready && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 100) chk("req_ready_timeout", 0, 1);
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = 8'(l);
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        chk("arvalid_after_accept", ARVALID, 1);
        chk("req_ready_busy", req_ready, 0);
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        bit ok = 0;
        while (!ok && n < max) begin
            @(posedge clk);
            #2;
            n++;
            ok = (exp_q.size() == 0) && req_ready && !s_active && !done;
        end
        if (!ok) chk("burst_timeout", 0, 1);
    endtask

    task automatic wait_beat(input int b, input int max);
        int n = 0;
        while (s_beat < b && n < max) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (s_beat < b) chk("beat_timeout", 0, 1);
    endtask

    initial begin : main
        int p0;
        int h0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        out_ready = 1'b1;
        exp_addr  = '0;
        exp_len   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Basic 8-beat burst, always-ready slave and consumer
        p0 = pop_cnt;
        issue(32'h100, 7);
        wait_done(300);
        chk("t1_beats", pop_cnt - p0, 8);
        chk("t1_err", err, 0);

        // Random RVALID with AR stall of 3 cycles
        ar_delay  = 3;
        rand_mode = 1;
        p0 = pop_cnt;
        issue(32'h100, 7);
        wait_done(500);
        chk("t2_beats", pop_cnt - p0, 8);
        ar_delay  = 0;
        rand_mode = 0;

        // Backpressure: FIFO fills to 2, RREADY drops
        out_ready = 1'b0;
        p0 = pop_cnt;
        h0 = r_hs_total;
        issue(32'h180, 3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("t3_rready_low", RREADY, 0);
        chk("t3_held_beats", r_hs_total - h0, 2);
        chk("t3_out_valid", out_valid, 1);
        chk("t3_no_pops", pop_cnt - p0, 0);
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait_done(300);
        chk("t3_beats", pop_cnt - p0, 4);

        // Single-beat burst
        p0 = pop_cnt;
        issue(32'h40, 0);
        wait_done(100);
        chk("t4_beats", pop_cnt - p0, 1);

        // RRESP error on beat 2, sticky until the next accept
        err_beat = 2;
        issue(32'h300, 3);
        wait_beat(3, 100);
        @(negedge clk);
        chk("t5_err_set", err, 1);
        wait_done(100);
        repeat (3) @(posedge clk);
        #2;
        chk("t5_err_sticky", err, 1);
        err_beat = -1;
        issue(32'h340, 1);
        chk("t5_err_cleared", err, 0);
        wait_done(100);
        chk("t5_err_ok", err, 0);

        // Spurious RLAST on beat 1
        bad_last_beat = 1;
        issue(32'h380, 3);
        wait_done(100);
        chk("t5_rlast_err", err, RLAST_ERR_EXP);
        bad_last_beat = -1;

        // Reset in the middle of a burst, then a normal burst
        issue(32'h500, 7);
        wait_beat(4, 100);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk_reset_vals("midrst");
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        p0 = pop_cnt;
        issue(32'h200, 1);
        wait_done(100);
        chk("t6_beats", pop_cnt - p0, 2);
        chk("t6_err", err, 0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
